// File: rtl/asynrevem_tx.sv
// asynrevem_tx: transmit side of the two-wire return-to-zero pulse link.
// Serialises a WIDTH-bit word MSB-first as single-cycle rail pulses
// (10 = '1', 01 = '0'). Each pulse is followed by one 00 spacer, and the
// frame ends with GAP idle cycles.
// Optional build macro: ASYNREVEM_TX_PARITY_EN appends an even-parity symbol
// after the LSB.
module asynrevem_tx #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned GAP   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [1:0]       out,
   output logic             busy
);

`ifdef ASYNREVEM_TX_PARITY_EN
   localparam int unsigned PAR_BITS = 1;
`else
   localparam int unsigned PAR_BITS = 0;
`endif
   // Symbols per frame: data bits plus the optional parity bit.
   localparam int unsigned SW       = WIDTH + PAR_BITS;
   localparam int unsigned CNT_W    = $clog2(SW + 1);
   localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int unsigned GAP_LAST = (GAP == 0) ? 0 : GAP - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MARK  = 2'd1,
      S_SPACE = 2'd2,
      S_GAP   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [SW-1:0]      shift_q, shift_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [1:0]         out_q, out_d;
   logic               busy_q, busy_d;
   logic [SW-1:0]      load_word;
   logic [SW-1:0]      shifted;

   function automatic logic [1:0] rail_code(input logic b);
      return b ? 2'b10 : 2'b01;
   endfunction

   // Word as it enters the shift register; parity rides behind the LSB.
`ifdef ASYNREVEM_TX_PARITY_EN
   assign load_word = {data_in, ^data_in};
`else
   assign load_word = data_in;
`endif

   assign shifted   = shift_q << 1;
   assign ready_out = (state_q == S_IDLE);
   assign out       = out_q;
   assign busy      = busy_q;

   // Next-state and next-output logic for the symbol sequencer.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      out_d     = 2'b00;
      busy_d    = busy_q;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (valid_in) begin
               shift_d   = load_word;
               bit_cnt_d = '0;
               state_d   = S_MARK;
               out_d     = rail_code(load_word[SW-1]);
               busy_d    = 1'b1;
            end
         end
         S_MARK: begin
            state_d = S_SPACE;
         end
         S_SPACE: begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q != CNT_W'(SW - 1)) begin
               state_d = S_MARK;
               out_d   = rail_code(shifted[SW-1]);
            end else if (GAP == 0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d   = S_GAP;
               gap_cnt_d = '0;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         out_q     <= 2'b00;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         out_q     <= out_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_asynrevem_tx.sv
// Testbench for asynrevem_tx: a GAP=2 instance and a GAP=0 instance,
// checked against a frame-level reference model.
module tb_asynrevem_tx;

   localparam int W = 8;
   localparam int G = 2;
`ifdef ASYNREVEM_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NS  = W + P;
   localparam int FL  = 2 * NS + G;
   localparam int FL0 = 2 * NS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, valid_in, ready_out, busy;
   logic [W-1:0] data_in;
   logic [1:0]   out;
   logic         rst0, valid0, ready0, busy0;
   logic [W-1:0] data0;
   logic [1:0]   out0;

   int total = 0;
   int bad   = 0;

   asynrevem_tx #(.WIDTH(W), .GAP(G)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .out(out), .busy(busy));

   asynrevem_tx #(.WIDTH(W), .GAP(0)) dut0 (
      .clk(clk), .rst(rst0), .data_in(data0), .valid_in(valid0),
      .ready_out(ready0), .out(out0), .busy(busy0));

   // Reference model: a frame is the list of rail values for each symbol
   // (code then spacer) followed by gap zeros; it is replayed one per cycle.
   int         m_pos [2] = '{0, 0};
   int         m_len [2] = '{0, 0};
   logic [W-1:0] m_word [2];
   logic [1:0] m_out [2] = '{2'b00, 2'b00};
   logic       m_busy [2] = '{1'b0, 1'b0};

   function automatic logic [1:0] frame_elem(input logic [W-1:0] w, input int idx);
      int   k;
      logic b;
      if (idx >= 2 * NS) return 2'b00;
      if (idx % 2 == 1) return 2'b00;
      k = idx / 2;
      if (k < W) b = w[W-1-k];
      else b = ^w;
      return b ? 2'b10 : 2'b01;
   endfunction

   task automatic model_step(input int ch, input logic r, input logic v,
                             input logic [W-1:0] d, input int gap);
      if (r) begin
         m_pos[ch] = 0; m_len[ch] = 0; m_out[ch] = 2'b00; m_busy[ch] = 1'b0;
      end else if (m_pos[ch] < m_len[ch]) begin
         m_out[ch] = frame_elem(m_word[ch], m_pos[ch]);
         m_pos[ch]++;
         m_busy[ch] = 1'b1;
      end else if (!m_busy[ch] && v) begin
         m_word[ch] = d;
         m_len[ch]  = 2 * NS + gap;
         m_out[ch]  = frame_elem(d, 0);
         m_pos[ch]  = 1;
         m_busy[ch] = 1'b1;
      end else begin
         m_out[ch] = 2'b00; m_busy[ch] = 1'b0;
      end
   endtask

   // Advance both model channels on every active edge.
   always @(posedge clk) begin
      model_step(0, rst, valid_in, data_in, G);
      model_step(1, rst0, valid0, data0, 0);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; rst0 = 1'b1; valid_in = 1'b0; valid0 = 1'b0;
      data_in = '0; data0 = '0;
      step(); step();
      rst = 1'b0; rst0 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         total++; if (out !== 2'b00) begin bad++; $display("FAIL reset_out cyc=%0d got=%b exp=00", i, out); end
         total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", i, ready_out); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy); end
      end
      total++; if (ready0 !== 1'b1 || busy0 !== 1'b0 || out0 !== 2'b00) begin
         bad++; $display("FAIL reset_gap0 got ready=%b busy=%b out=%b exp 1 0 00", ready0, busy0, out0);
      end
   endtask

   task automatic test_a5;
      logic [31:0] seq;
      logic [1:0]  lit [FL];
      seq = 32'b10_00_01_00_10_00_01_00_01_00_10_00_01_00_10_00;
      for (int i = 0; i < FL; i++) begin
         if (i < 16) lit[i] = seq[31-2*i -: 2];
         else if (P == 1 && i == 16) lit[i] = 2'b01;
         else lit[i] = 2'b00;
      end
      data_in = 8'hA5; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int i = 0; i < FL; i++) begin
         total++; if (out !== lit[i]) begin bad++; $display("FAIL a5_out cyc=%0d got=%b exp=%b", i + 1, out, lit[i]); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL a5_busy cyc=%0d got=%b exp=1", i + 1, busy); end
         total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL a5_ready cyc=%0d got=%b exp=0", i + 1, ready_out); end
         data_in = W'($urandom);
         step();
      end
      total++; if (ready_out !== 1'b1 || busy !== 1'b0 || out !== 2'b00) begin
         bad++; $display("FAIL a5_end got ready=%b busy=%b out=%b exp 1 0 00", ready_out, busy, out);
      end
   endtask

   task automatic test_back_to_back;
      int pulses;
      pulses = 0;
      data_in = 8'hA5; valid_in = 1'b1;
      step();
      data_in = 8'h3C;
      for (int i = 0; i < FL; i++) begin
         total++; if (out !== m_out[0]) begin bad++; $display("FAIL b2b_a5_out cyc=%0d got=%b exp=%b", i + 1, out, m_out[0]); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_a5_busy cyc=%0d got=%b exp=1", i + 1, busy); end
         if (out != 2'b00) pulses++;
         step();
      end
      total++; if (pulses != NS) begin bad++; $display("FAIL b2b_pulses got=%0d exp=%0d", pulses, NS); end
      total++; if (ready_out !== 1'b1 || out !== 2'b00 || busy !== 1'b0) begin
         bad++; $display("FAIL b2b_idle got ready=%b out=%b busy=%b exp 1 00 0", ready_out, out, busy);
      end
      step();
      valid_in = 1'b0;
      total++; if (out !== 2'b01 || busy !== 1'b1) begin
         bad++; $display("FAIL b2b_3c_first got out=%b busy=%b exp 01 1", out, busy);
      end
      for (int i = 1; i < FL; i++) begin
         step();
         total++; if (out !== m_out[0]) begin bad++; $display("FAIL b2b_3c_out cyc=%0d got=%b exp=%b", i + 1, out, m_out[0]); end
      end
      step();
      total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL b2b_3c_end got=%b exp=1", ready_out); end
   endtask

   task automatic test_reset_mid;
      data_in = 8'hFF; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         total++; if (out !== ((i % 2 == 1) ? 2'b10 : 2'b00)) begin
            bad++; $display("FAIL rmid_pre cyc=%0d got=%b", i, out);
         end
         if (i < 5) step();
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (out !== 2'b00 || ready_out !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL rmid_after got out=%b ready=%b busy=%b exp 00 1 0", out, ready_out, busy);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         total++; if (out !== 2'b00 || ready_out !== 1'b1) begin
            bad++; $display("FAIL rmid_quiet cyc=%0d got out=%b ready=%b exp 00 1", i, out, ready_out);
         end
      end
   endtask

`ifdef ASYNREVEM_TX_PARITY_EN
   task automatic test_parity;
      logic [W-1:0] words [2];
      logic [1:0]   pcode [2];
      words = '{8'h07, 8'h03};
      pcode = '{2'b10, 2'b01};
      for (int w = 0; w < 2; w++) begin
         data_in = words[w]; valid_in = 1'b1;
         step();
         valid_in = 1'b0;
         for (int i = 0; i < FL; i++) begin
            total++; if (out !== m_out[0] || busy !== 1'b1) begin
               bad++; $display("FAIL par_frame w=%0d cyc=%0d got=%b exp=%b busy=%b", w, i + 1, out, m_out[0], busy);
            end
            if (i == 16) begin
               total++; if (out !== pcode[w]) begin bad++; $display("FAIL par_bit w=%0d got=%b exp=%b", w, out, pcode[w]); end
            end
            step();
         end
         total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL par_end w=%0d got=%b exp=1", w, ready_out); end
      end
   endtask
`endif

   task automatic test_gap0;
      data0 = 8'h80; valid0 = 1'b1;
      step();
      data0 = 8'h01;
      total++; if (out0 !== 2'b10) begin bad++; $display("FAIL gap0_first got=%b exp=10", out0); end
      for (int i = 0; i < FL0; i++) begin
         total++; if (out0 !== m_out[1] || busy0 !== 1'b1) begin
            bad++; $display("FAIL gap0_frame cyc=%0d got=%b exp=%b busy=%b", i + 1, out0, m_out[1], busy0);
         end
         step();
      end
      total++; if (out0 !== 2'b00 || ready0 !== 1'b1 || busy0 !== 1'b0) begin
         bad++; $display("FAIL gap0_idle got out=%b ready=%b busy=%b exp 00 1 0", out0, ready0, busy0);
      end
      step();
      valid0 = 1'b0;
      total++; if (out0 !== 2'b01 || busy0 !== 1'b1) begin
         bad++; $display("FAIL gap0_next got out=%b busy=%b exp 01 1", out0, busy0);
      end
      for (int i = 1; i < FL0; i++) begin
         step();
         total++; if (out0 !== m_out[1]) begin bad++; $display("FAIL gap0_second cyc=%0d got=%b exp=%b", i + 1, out0, m_out[1]); end
      end
      step();
      total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL gap0_end got=%b exp=1", ready0); end
   endtask

   task automatic test_random;
      logic [1:0] prev;
      prev = 2'b00;
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 49) == 0);
         valid_in = ($urandom_range(0, 2) != 0);
         data_in  = W'($urandom);
         step();
         total++; if (out !== m_out[0]) begin bad++; $display("FAIL rnd_out n=%0d got=%b exp=%b", n, out, m_out[0]); end
         total++; if (busy !== m_busy[0]) begin bad++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, m_busy[0]); end
         total++; if (ready_out !== !m_busy[0]) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, ready_out, !m_busy[0]); end
         total++; if (prev != 2'b00 && out != 2'b00) begin
            bad++; $display("FAIL rnd_rail n=%0d got=%b after %b exp spacer", n, out, prev);
         end
         prev = out;
      end
      rst = 1'b0; valid_in = 1'b0;
      for (int i = 0; i < FL + 2; i++) step();
      total++; if (ready_out !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL rnd_drain got ready=%b busy=%b exp 1 0", ready_out, busy);
      end
   endtask

   initial begin
      rst = 1'b1; rst0 = 1'b1;
      valid_in = 1'b0; valid0 = 1'b0;
      data_in = '0; data0 = '0;
      test_reset();
      test_a5();
      test_back_to_back();
      test_reset_mid();
`ifdef ASYNREVEM_TX_PARITY_EN
      test_parity();
`endif
      test_gap0();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/asynrevem_tx.md
Name: asynrevem_tx

Overview:
- Transmit end of the two-wire return-to-zero pulse link. Each bit is a single-cycle pulse on one of two rails: out=2'b10 for a '1', out=2'b01 for a '0'. Every pulse is followed by one all-zero spacer cycle.
- Accepts a parallel word over a valid/ready handshake and serialises it MSB-first. An inter-frame gap follows each frame.
- Sits between the local data source and the physical pulse pair that feeds the asynrevem receiver.

Parameters:
- WIDTH, 8, data bits per frame; legal range 1 or more.
- GAP, 2, spacer cycles (out=2'b00) after the last symbol of a frame; 0 is legal.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to send; sampled only on an accept edge.
- valid_in  input  1  source has a word.
- ready_out  output  1  block can accept a word this cycle.
- out  output  2  pulse rails; 2'b10 means '1', 2'b01 means '0', 2'b00 means spacer/idle; 2'b11 is never driven.
- busy  output  1  a frame is in progress, including the gap.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset values: out=2'b00, ready_out=1, busy=0, state=IDLE, shift register=0, bit counter=0.
- Outputs:
  - out and busy are registered.
  - ready_out is combinational: it equals (state==IDLE).
- Accept: happens on the rising edge where valid_in && ready_out. On that edge:
  - load data_in into the shift register;
  - state goes to MARK;
  - out takes the code of data_in[WIDTH-1];
  - busy goes to 1.
  - The first pulse is therefore visible in the cycle right after accept (latency 1).
- States:
  - IDLE: out=00. Go to MARK on accept, otherwise stay.
  - MARK: one cycle with the bit pulse on out. Next state is SPACE, and out goes to 00.
  - SPACE: one cycle, out=00. Shift left and increment the bit counter.
    - If symbols remain, go to MARK and drive the next bit's code.
    - Otherwise go to GAP, or to IDLE if GAP==0.
  - GAP: out=00 for exactly GAP cycles, counted by the gap counter. Then go to IDLE.
- Frame timing: one frame occupies 2*WIDTH + GAP cycles of busy=1, measured from the cycle after accept. ready_out returns to 1 in the following cycle.
- Back-to-back frames: valid_in held high through a frame is accepted on the first IDLE cycle. A new word's first MARK directly follows that single IDLE cycle.
- valid_in while busy: ignored. data_in changes while busy have no effect on the frame in flight.
- Reset mid-frame: the frame is aborted on that edge. out=00, busy=0 and ready_out=1 from the next cycle. No partial symbols or trailing pulses follow.
- Rail safety: out never equals 2'b11, and never shows two consecutive non-zero cycles.

Optional Feature:
- ASYNREVEM_TX_PARITY_EN defined:
  - An extra parity symbol (MARK+SPACE) is sent after the LSB and before GAP.
  - The parity value is even parity, i.e. XOR of all WIDTH data bits.
  - Frame length becomes 2*(WIDTH+1) + GAP.
- Undefined: no parity symbol. The frame is exactly WIDTH symbols plus GAP.

Test Plan:
- Reset, then hold valid_in=0 for 10 cycles -> out=00, ready_out=1, busy=0 throughout.
- Send 8'hA5 (WIDTH=8, GAP=2, parity off) -> out per cycle after accept: 10,00,01,00,10,00,01,00,01,00,10,00,01,00,10,00,00,00. busy=1 for those 18 cycles; ready_out=1 on cycle 19.
- Hold valid_in=1 with 8'h3C while 8'hA5 is in flight -> 3C is accepted only in the first IDLE cycle. Its first pulse (01) appears in the next cycle, and no A5 symbol is lost or repeated.
- Assert rst for one cycle right after the third MARK of 8'hFF -> out=00 and ready_out=1 on the next cycle. No further pulses appear until a new accept.
- With ASYNREVEM_TX_PARITY_EN, send 8'h07 -> the 8 data symbols are followed by parity pulse 10 then spacer 00, then 2 gap cycles. The frame is 20 cycles. Sending 8'h03 gives a parity pulse of 01.
- GAP=0 build, two back-to-back words 8'h80 and 8'h01 -> the last SPACE of the first frame is followed by exactly one IDLE cycle (out=00, ready_out=1). The next MARK is 01 for the MSB of 8'h01.
